// File: rtl/ex_issue_buffer.sv
// ex_issue_buffer: decode-to-execute issue stage feeding the ALU.
// Two-entry FIFO skid buffer with valid/ready handshakes on both sides,
// registered ALU-side outputs, operand forwarding snoop from EX/MEM and
// MEM/WB, and saturating issue/stall counters.
// Build option: define EX_FWD_EN to enable the forwarding snoop; when it is
// undefined the fwd* ports are present but ignored.
module ex_issue_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_aluctr,
  input  logic [DATA_W-1:0] in_opa,
  input  logic [DATA_W-1:0] in_opb,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_b_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              fwd1_valid,
  input  logic [REG_AW-1:0] fwd1_rd,
  input  logic [DATA_W-1:0] fwd1_data,
  input  logic              fwd2_valid,
  input  logic [REG_AW-1:0] fwd2_rd,
  input  logic [DATA_W-1:0] fwd2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [3:0]        ALUctr,
  output logic [REG_AW-1:0] out_rd,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [3:0]        aluctr;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              b_imm;
    logic [REG_AW-1:0] rd;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  ent_t             r_e0;       // head entry, drives the ALU outputs
  ent_t             r_e1;       // second entry, valid only when FULL
  ent_t             w_in;
  ent_t             w_f0;
  ent_t             w_f1;
  ent_t             w_fin;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;
  logic             w_in_ready;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in = '{aluctr: in_aluctr, opa: in_opa, opb: in_opb, rs: in_rs,
                  rt: in_rt, b_imm: in_b_imm, rd: in_rd};

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_ready  = (r_state != S_FULL);
  assign w_push      = in_valid & w_in_ready & ~flush;
  assign w_pop       = w_out_valid & out_ready & ~flush;

`ifdef EX_FWD_EN
  // EX/MEM takes priority over MEM/WB; r0 and immediates are never replaced.
  function automatic ent_t snoop(input ent_t              e,
                                 input logic              v1,
                                 input logic [REG_AW-1:0] rd1,
                                 input logic [DATA_W-1:0] d1,
                                 input logic              v2,
                                 input logic [REG_AW-1:0] rd2,
                                 input logic [DATA_W-1:0] d2);
    ent_t r;
    r = e;
    if (e.rs != '0) begin
      if (v1 && (rd1 == e.rs))      r.opa = d1;
      else if (v2 && (rd2 == e.rs)) r.opa = d2;
    end
    if (!e.b_imm && (e.rt != '0)) begin
      if (v1 && (rd1 == e.rt))      r.opb = d1;
      else if (v2 && (rd2 == e.rt)) r.opb = d2;
    end
    return r;
  endfunction

  // Snoop forwarding buses on both stored entries and the incoming op.
  always_comb begin
    w_f0  = snoop(r_e0, fwd1_valid, fwd1_rd, fwd1_data, fwd2_valid, fwd2_rd, fwd2_data);
    w_f1  = snoop(r_e1, fwd1_valid, fwd1_rd, fwd1_data, fwd2_valid, fwd2_rd, fwd2_data);
    w_fin = snoop(w_in, fwd1_valid, fwd1_rd, fwd1_data, fwd2_valid, fwd2_rd, fwd2_data);
  end
`else
  logic w_unused_fwd;

  // Forwarding disabled: operands pass through exactly as received.
  always_comb begin
    w_f0  = r_e0;
    w_f1  = r_e1;
    w_fin = w_in;
  end

  assign w_unused_fwd = ^{fwd1_valid, fwd1_rd, fwd1_data, fwd2_valid, fwd2_rd,
                          fwd2_data, r_e0.rs, r_e0.rt, r_e0.b_imm,
                          r_e1.rs, r_e1.rt, r_e1.b_imm};
`endif

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Occupancy next-state: flush empties the buffer and overrides push/pop.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: if (w_push) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = S_FULL;
          else if (w_pop && !w_push) w_state_nxt = S_EMPTY;
        end
        S_FULL:  if (w_pop) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Entry storage. The head is only rewritten while it stays valid or when a
  // new head arrives, so a/b/ALUctr/out_rd hold their last value while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0 <= '0;
      r_e1 <= '0;
    end else if (!flush) begin
      unique case (r_state)
        S_EMPTY: if (w_push) r_e0 <= w_fin;
        S_ONE: begin
          if (w_pop) begin
            if (w_push) r_e0 <= w_fin;
          end else begin
            r_e0 <= w_f0;
            if (w_push) r_e1 <= w_fin;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_e0 <= w_f1;
          end else begin
            r_e0 <= w_f0;
            r_e1 <= w_f1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating issue and stall counters; flush cycles count neither.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (!flush) begin
      if (w_pop && (r_issue_cnt != '1))
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (w_out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign a         = r_e0.opa;
  assign b         = r_e0.opb;
  assign ALUctr    = r_e0.aluctr;
  assign out_rd    = r_e0.rd;
  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_issue_buffer.sv
// Self-checking bench for ex_issue_buffer: queue-based reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_ex_issue_buffer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [3:0]    in_aluctr;
  logic [DW-1:0] in_opa, in_opb;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic          in_b_imm;
  logic          fwd1_valid, fwd2_valid;
  logic [AW-1:0] fwd1_rd, fwd2_rd;
  logic [DW-1:0] fwd1_data, fwd2_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] a, b;
  logic [3:0]    ALUctr;
  logic [AW-1:0] out_rd;
  logic [CW-1:0] issue_cnt, stall_cnt;

  ex_issue_buffer #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluctr(in_aluctr),
    .in_opa(in_opa), .in_opb(in_opb), .in_rs(in_rs), .in_rt(in_rt),
    .in_b_imm(in_b_imm), .in_rd(in_rd),
    .fwd1_valid(fwd1_valid), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
    .fwd2_valid(fwd2_valid), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
    .ALUctr(ALUctr), .out_rd(out_rd), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]    ctr;
    logic [DW-1:0] opa, opb;
    logic [AW-1:0] rs, rt, rd;
    logic          bimm;
  } op_t;

  op_t           mq[$];
  logic [DW-1:0] m_a, m_b;
  logic [3:0]    m_ctr;
  logic [AW-1:0] m_rd;
  int            m_issue, m_stall;
  bit            live = 0;

  function automatic op_t m_fwd(input op_t o);
    op_t r = o;
    if (o.rs != 0 && fwd1_valid && fwd1_rd == o.rs)      r.opa = fwd1_data;
    else if (o.rs != 0 && fwd2_valid && fwd2_rd == o.rs) r.opa = fwd2_data;
    if (!o.bimm && o.rt != 0 && fwd1_valid && fwd1_rd == o.rt)      r.opb = fwd1_data;
    else if (!o.bimm && o.rt != 0 && fwd2_valid && fwd2_rd == o.rt) r.opb = fwd2_data;
    return r;
  endfunction

  always @(posedge clk) begin : model
    int  sz;
    bit  do_pop, do_push;
    op_t nop;
    if (rst) begin
      mq.delete();
      m_a = 0; m_b = 0; m_ctr = 0; m_rd = 0;
      m_issue = 0; m_stall = 0;
      live = 1;
    end else begin
      sz      = mq.size();
      do_pop  = (sz > 0) && out_ready && !flush;
      do_push = in_valid && (sz < 2) && !flush;
      nop = '{ctr: in_aluctr, opa: in_opa, opb: in_opb, rs: in_rs, rt: in_rt,
               rd: in_rd, bimm: in_b_imm};
`ifdef EX_FWD_EN
      foreach (mq[i]) mq[i] = m_fwd(mq[i]);
      nop = m_fwd(nop);
`endif
      if (sz > 0 && !out_ready && !flush && m_stall < 65535) m_stall++;
      if (flush) mq.delete();
      if (do_pop) begin
        void'(mq.pop_front());
        if (m_issue < 65535) m_issue++;
      end
      if (do_push) mq.push_back(nop);
      if (mq.size() > 0) begin
        m_a = mq[0].opa; m_b = mq[0].opb; m_ctr = mq[0].ctr; m_rd = mq[0].rd;
      end
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (live) begin
      chk("cmp_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("cmp_in_ready",  64'(in_ready),  64'(mq.size() < 2));
      chk("cmp_a",         64'(a),         64'(m_a));
      chk("cmp_b",         64'(b),         64'(m_b));
      chk("cmp_aluctr",    64'(ALUctr),    64'(m_ctr));
      chk("cmp_out_rd",    64'(out_rd),    64'(m_rd));
      chk("cmp_issue_cnt", 64'(issue_cnt), 64'(m_issue));
      chk("cmp_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [3:0] c, input logic [DW-1:0] oa, input logic [DW-1:0] ob,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic bi,
                        input logic [AW-1:0] rd);
    in_valid = 1; in_aluctr = c; in_opa = oa; in_opb = ob;
    in_rs = rs; in_rt = rt; in_b_imm = bi; in_rd = rd;
  endtask

  task automatic fwd_off();
    fwd1_valid = 0; fwd1_rd = 0; fwd1_data = 0;
    fwd2_valid = 0; fwd2_rd = 0; fwd2_data = 0;
  endtask

  int saved_issue;

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_aluctr = 0; in_opa = 0; in_opb = 0; in_rs = 0; in_rt = 0; in_b_imm = 0; in_rd = 0;
    fwd_off();
    tick(); tick();
    rst = 0;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready",  64'(in_ready), 1);
    chk("rst_a",         64'(a), 0);
    chk("rst_b",         64'(b), 0);
    chk("rst_cnts",      64'({issue_cnt, stall_cnt}), 0);

    // Single op, one-cycle latency, then popped.
    out_ready = 1;
    set_op(4'b0010, 5, 7, 1, 2, 0, 9);
    tick();
    in_valid = 0;
    chk("t1_out_valid", 64'(out_valid), 1);
    chk("t1_a",         64'(a), 5);
    chk("t1_b",         64'(b), 7);
    chk("t1_aluctr",    64'(ALUctr), 2);
    chk("t1_out_rd",    64'(out_rd), 9);
    tick();
    chk("t1_issue", 64'(issue_cnt), 1);
    chk("t1_empty", 64'(out_valid), 0);

    // Back-to-back with ALU stalled, then in-order drain.
    out_ready = 0;
    set_op(3, 'h11, 'h12, 0, 0, 0, 1);
    tick();
    set_op(4, 'h21, 'h22, 0, 0, 0, 2);
    tick();
    chk("t2_full_ready", 64'(in_ready), 0);
    chk("t2_head1",      64'(a), 'h11);
    set_op(5, 'h31, 'h32, 0, 0, 0, 3);
    tick(); tick();
    chk("t2_held_head", 64'(a), 'h11);
    chk("t2_stall",     64'(stall_cnt), 3);
    out_ready = 1;
    tick();
    chk("t2_head2", 64'(a), 'h21);
    tick();
    in_valid = 0;
    chk("t2_head3",    64'(a), 'h31);
    chk("t2_head3_rd", 64'(out_rd), 3);
    tick();
    chk("t2_drained", 64'(out_valid), 0);
    chk("t2_issue",   64'(issue_cnt), 4);

    // Forwarding priority and persistence on operand A.
    out_ready = 0;
    set_op(6, 'h1111_1111, 'h2222, 3, 6, 0, 7);
    tick();
    in_valid = 0;
    fwd1_valid = 1; fwd1_rd = 3; fwd1_data = 'hAAAA;
    fwd2_valid = 1; fwd2_rd = 3; fwd2_data = 'hBBBB;
    tick();
    fwd_off();
`ifdef EX_FWD_EN
    chk("t3_fwd1_prio", 64'(a), 'hAAAA);
`else
    chk("t3_no_fwd_a", 64'(a), 'h1111_1111);
`endif
    chk("t3_b_untouched", 64'(b), 'h2222);
    tick();
`ifdef EX_FWD_EN
    chk("t3_persist", 64'(a), 'hAAAA);
`else
    chk("t3_persist", 64'(a), 'h1111_1111);
`endif

    // rs=0 never forwarded, immediate opB never forwarded.
    out_ready = 1;
    set_op(8, 'h55, 'h66, 0, 4, 1, 1);
    tick();
    out_ready = 0; in_valid = 0;
    fwd1_valid = 1; fwd1_rd = 0; fwd1_data = 'hDEAD;
    tick();
    fwd1_rd = 4; fwd1_data = 'h1234;
    tick();
    fwd_off();
    chk("t4_rs0_a",  64'(a), 'h55);
    chk("t4_imm_b",  64'(b), 'h66);

    // MEM/WB forwarding on operand B when EX/MEM is not valid.
    out_ready = 1;
    set_op(9, 'h77, 'h88, 2, 5, 0, 3);
    tick();
    out_ready = 0; in_valid = 0;
    fwd1_valid = 0; fwd1_rd = 5; fwd1_data = 'hCAFE;
    fwd2_valid = 1; fwd2_rd = 5; fwd2_data = 'hBEEF;
    tick();
    fwd_off();
`ifdef EX_FWD_EN
    chk("t4_fwd2_b", 64'(b), 'hBEEF);
`else
    chk("t4_fwd2_b", 64'(b), 'h88);
`endif
    chk("t4_a_keep", 64'(a), 'h77);

    // Flush while FULL overrides pop and push.
    out_ready = 1;
    tick();
    out_ready = 0;
    set_op(1, 'h41, 'h42, 0, 0, 0, 4);
    tick();
    set_op(1, 'h51, 'h52, 0, 0, 0, 5);
    tick();
    chk("t5_full", 64'(in_ready), 0);
    saved_issue = m_issue;
    out_ready = 1; flush = 1;
    set_op(1, 'h61, 'h62, 0, 0, 0, 6);
    tick();
    flush = 0; in_valid = 0;
    chk("t5_out_valid", 64'(out_valid), 0);
    chk("t5_in_ready",  64'(in_ready), 1);
    chk("t5_issue",     64'(issue_cnt), 64'(saved_issue));
    chk("t5_a_hold",    64'(a), 'h41);
    tick();
    chk("t5_still_empty", 64'(out_valid), 0);

    // Mid-operation reset with stall_cnt=9.
    rst = 1;
    tick();
    rst = 0; out_ready = 0;
    set_op(2, 'h71, 'h72, 0, 0, 0, 8);
    tick();
    in_valid = 0;
    repeat (9) tick();
    chk("t6_stall9",     64'(stall_cnt), 9);
    chk("t6_valid",      64'(out_valid), 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_out_valid", 64'(out_valid), 0);
    chk("t6_cnts",      64'({issue_cnt, stall_cnt}), 0);
    chk("t6_ab",        64'({a, b}), 0);
    chk("t6_in_ready",  64'(in_ready), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
